// File: rtl/arb_pkg.sv
// Shared types and constants for the two-channel burst arbiter.
package arb_pkg;
  typedef enum logic {FREE = 1'b0, OWN = 1'b1} arb_state_e;
  localparam int unsigned BURST_DEF = 4;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mux2_8.sv
// 8-bit two-input data select.
module mux2_8 (
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic       s,
  output logic [7:0] y
);
  assign y = s ? d1 : d0;
endmodule

// File: rtl/arb2_8.sv
// Two-channel round-robin arbiter with burst ownership feeding a single
// registered output stage (load = ~yv | yr).
module arb2_8
  import arb_pkg::*;
#(
  parameter int unsigned BURST = BURST_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d0,
  input  logic       v0,
  output logic       r0,
  input  logic [7:0] d1,
  input  logic       v1,
  output logic       r1,
  output logic [7:0] y,
  output logic       yv,
  input  logic       yr,
  output logic       sel
);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  arb_state_e       r_state;
  logic             r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_sel_prev;
  logic [7:0]       r_y;
  logic             r_yv;

  logic             w_load;
  logic             w_hold_own;
  logic             w_sel;
  logic             w_gnt;
  logic             w_xfer;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_mux;

  mux2_8 u_mux (
    .d0 (d0),
    .d1 (d1),
    .s  (w_sel),
    .y  (w_mux)
  );

  always_comb begin
    w_load     = ~r_yv | yr;
    w_hold_own = (r_state == OWN) && (r_owner ? v1 : v0);
    w_sel      = r_sel_prev;
    w_gnt      = 1'b0;
    // An owner whose valid drops falls through to free arbitration this cycle.
    if (w_hold_own) begin
      w_sel = r_owner;
      w_gnt = 1'b1;
    end else if (v0 && v1) begin
      w_sel = ~r_last;
      w_gnt = 1'b1;
    end else if (v0) begin
      w_sel = 1'b0;
      w_gnt = 1'b1;
    end else if (v1) begin
      w_sel = 1'b1;
      w_gnt = 1'b1;
    end
    r0        = w_load & ~reset & w_gnt & ~w_sel;
    r1        = w_load & ~reset & w_gnt &  w_sel;
    w_xfer    = r0 | r1;
    w_cnt_nxt = w_hold_own ? r_cnt + CNT_W'(1) : CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FREE;
      r_owner    <= 1'b0;
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_sel_prev <= 1'b0;
      r_y        <= 8'h00;
      r_yv       <= 1'b0;
    end else if (w_load) begin
      r_sel_prev <= w_sel;
      if (r_state == OWN && !w_hold_own) begin
        r_state <= FREE;
        r_cnt   <= '0;
        r_last  <= r_owner;
      end
      if (w_xfer) begin
        r_y  <= w_mux;
        r_yv <= 1'b1;
        if (w_cnt_nxt == BURST_C) begin
          r_state <= FREE;
          r_cnt   <= '0;
          r_last  <= w_sel;
        end else begin
          r_state <= OWN;
          r_owner <= w_sel;
          r_cnt   <= w_cnt_nxt;
        end
      end else begin
        r_yv <= 1'b0;
      end
    end
  end

  assign y   = r_y;
  assign yv  = r_yv;
  assign sel = w_sel;
endmodule

// File: tb/tb_arb2_8.sv
// Scoreboard bench for arb2_8: BURST=4 instance for the main scenarios,
// BURST=1 instance for pure alternation.
module tb_arb2_8;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0, d1, y;
  logic       v0, v1, r0, r1, yv, yr, sel;
  logic [7:0] d0b, d1b, yb;
  logic       v0b, v1b, r0b, r1b, yvb, yrb, selb;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  arb2_8 #(.BURST(4)) dut (
    .clk(clk), .reset(reset), .d0(d0), .v0(v0), .r0(r0), .d1(d1), .v1(v1),
    .r1(r1), .y(y), .yv(yv), .yr(yr), .sel(sel)
  );

  arb2_8 #(.BURST(1)) dut1 (
    .clk(clk), .reset(reset), .d0(d0b), .v0(v0b), .r0(r0b), .d1(d1b), .v1(v1b),
    .r1(r1b), .y(yb), .yv(yvb), .yr(yrb), .sel(selb)
  );

  // Every beat consumed downstream is checked against the expected queue.
  always @(negedge clk) begin
    if (!reset && yv === 1'b1 && yr === 1'b1) begin
      logic [7:0] exp_y;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got y=%02h, expected no beat", y);
      end else begin
        exp_y = sb.pop_front();
        if (y !== exp_y) begin
          n_fail++;
          $display("FAIL sb_beat: got y=%02h, expected %02h", y, exp_y);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22; yr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (y !== 8'h00 || yv !== 1'b0 || sel !== 1'b0 || r0 !== 1'b0 || r1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got y=%02h yv=%b sel=%b r0=%b r1=%b, expected 00 0 0 0 0",
               y, yv, sel, r0, r1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    d0 = 8'hA0; d1 = 8'hB0; v0 = 1'b1; v1 = 1'b1; yr = 1'b1;
    reset = 1'b0;
    for (int k = 0; k < 16; k++) sb.push_back(((k / 4) % 2) ? 8'hB0 : 8'hA0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_tests++;
      if ({r1, r0} !== (((k / 4) % 2) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL tie_grant[%0d]: got r1r0=%b%b, expected %b", k, r1, r0,
                 (((k / 4) % 2) ? 2'b10 : 2'b01));
      end
      if (k == 0 || k == 1) begin
        n_tests++;
        if (yv !== (k == 1)) begin
          n_fail++;
          $display("FAIL tie_first_yv[%0d]: got yv=%b, expected %b", k, yv, (k == 1));
        end
      end
      @(posedge clk); #1;
    end
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    @(negedge clk);
    n_tests++;
    if (yv !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_yv: got yv=%b, expected 0", yv);
    end
    @(posedge clk); #1;
    v1 = 1'b1; d1 = 8'h55; sb.push_back(8'h55);
    @(negedge clk);
    n_tests++;
    if (r1 !== 1'b1 || r0 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_pulse_ready: got r0=%b r1=%b, expected 0 1", r0, r1);
    end
    @(posedge clk); #1;
    v1 = 1'b0; d1 = 8'hFF;
    @(negedge clk);
    n_tests++;
    if (yv !== 1'b1 || y !== 8'h55) begin
      n_fail++;
      $display("FAIL idle_pulse_out: got yv=%b y=%02h, expected 1 55", yv, y);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (yv !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_pulse: got yv=%b, expected 0", yv);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_early_release();
    v0 = 1'b1; d0 = 8'h10; sb.push_back(8'h10);
    @(posedge clk); #1;
    d0 = 8'h11; sb.push_back(8'h11);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b1; d1 = 8'h20; sb.push_back(8'h20);
    @(negedge clk);
    n_tests++;
    if (r1 !== 1'b1 || r0 !== 1'b0) begin
      n_fail++;
      $display("FAIL release_ready: got r0=%b r1=%b, expected 0 1", r0, r1);
    end
    @(posedge clk); #1;
    d1 = 8'h21; sb.push_back(8'h21);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (yv !== 1'b1) begin
        n_fail++;
        $display("FAIL release_no_gap[%0d]: got yv=%b, expected 1", k, yv);
      end
      @(posedge clk); #1;
      v1 = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    v0 = 1'b1; d0 = 8'h3C; sb.push_back(8'h3C);
    @(posedge clk); #1;
    yr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d0 = 8'h40 + 8'(k);
      @(negedge clk);
      n_tests++;
      if (y !== 8'h3C || yv !== 1'b1 || r0 !== 1'b0 || r1 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got y=%02h yv=%b r0=%b r1=%b, expected 3C 1 0 0",
                 k, y, yv, r0, r1);
      end
      @(posedge clk); #1;
    end
    // Owner 0 already holds cnt=1, so three more ch0 beats precede ch1.
    yr = 1'b1; v1 = 1'b1; d0 = 8'hC1; d1 = 8'hD1;
    sb.push_back(8'hC1); sb.push_back(8'hC1); sb.push_back(8'hC1); sb.push_back(8'hD1);
    repeat (4) @(posedge clk);
    #1 v0 = 1'b0; v1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    v1 = 1'b1; d1 = 8'h61; sb.push_back(8'h61);
    @(posedge clk); #1;
    d1 = 8'h62;
    @(posedge clk); #1;
    reset = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'hA5; d1 = 8'hB5;
    @(negedge clk);
    n_tests++;
    if (r0 !== 1'b0 || r1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ready: got r0=%b r1=%b, expected 0 0", r0, r1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    sb.push_back(8'hA5);
    @(negedge clk);
    n_tests++;
    if (yv !== 1'b0 || r0 !== 1'b1 || r1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_grant: got yv=%b r0=%b r1=%b, expected 0 1 0", yv, r0, r1);
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    n_tests++;
    if (yv !== 1'b1 || y !== 8'hA5) begin
      n_fail++;
      $display("FAIL rst_mid_first: got yv=%b y=%02h, expected 1 A5", yv, y);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_burst1();
    v0b = 1'b1; v1b = 1'b1; d0b = 8'h01; d1b = 8'h02; yrb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (yvb !== 1'b1 || yb !== ((k % 2) ? 8'h02 : 8'h01)) begin
        n_fail++;
        $display("FAIL burst1_alt[%0d]: got yv=%b y=%02h, expected 1 %02h",
                 k, yvb, yb, ((k % 2) ? 8'h02 : 8'h01));
      end
    end
    #1 v0b = 1'b0; v1b = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; d0 = '0; d1 = '0; v0 = 1'b0; v1 = 1'b0; yr = 1'b1;
    d0b = '0; d1b = '0; v0b = 1'b0; v1b = 1'b0; yrb = 1'b1;
    test_reset();
    test_tie();
    test_idle();
    test_early_release();
    test_backpressure();
    test_reset_mid();
    test_burst1();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d beats outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
